// File: rtl/fp_pkg.sv
// Shared definitions for the 17-bit FloPoCo-style float format (wE=4, wF=10)
// used by the fmul/fdiv operator cores.
package fp_pkg;

  localparam int WE   = 4;
  localparam int WF   = 10;
  localparam int BIAS = 7;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  typedef struct packed {
    logic [1:0]    exc;
    logic          sign;
    logic [WE-1:0] exp;
    logic [WF-1:0] frac;
  } fp_t;

  // fdiv_iter controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DIV   = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic fp_t fp_special(input logic [1:0] exc, input logic sign);
    fp_t r;
    r      = '0;
    r.exc  = exc;
    r.sign = sign;
    return r;
  endfunction

endpackage

// File: rtl/sigdiv_radix2.sv
// Restoring radix-2 significand divider: one quotient bit per cycle for 12 cycles,
// leaving the quotient and a sticky flag from the final remainder.
module sigdiv_radix2
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [12:0]   rem_init,
  input  logic [WF:0]   divisor,
  output logic          done,
  output logic [WF+1:0] quot,
  output logic          sticky
);

  logic [12:0] rem;
  logic [WF:0] dvs;
  logic [3:0]  count;
  logic        active;
  logic        q_bit;
  logic [12:0] diff;

  assign q_bit  = (rem >= {2'b00, dvs});
  assign diff   = q_bit ? (rem - {2'b00, dvs}) : rem;
  assign done   = active && (count == 4'd11);
  assign sticky = (rem != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      count  <= '0;
      rem    <= '0;
      dvs    <= '0;
      quot   <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= '0;
      rem    <= rem_init;
      dvs    <= divisor;
      quot   <= '0;
    end else if (active) begin
      // diff < divisor < 2^11, so the shifted remainder never loses a bit
      rem   <= diff << 1;
      quot  <= {quot[WF:0], q_bit};
      count <= count + 4'd1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/fdiv_iter.sv
// Iterative float divider R = X / Y: exception decode, operand setup, handshakes
// and round-to-nearest-even around the sigdiv_radix2 significand divider.
//
// state    | meaning
// ST_IDLE  | waiting for operands, in_ready=1
// ST_DIV   | significand division running, one quotient bit per cycle
// ST_ROUND | rounding quotient and registering R
// ST_DONE  | R valid, held until out_ready
module fdiv_iter
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] X,
  input  logic [16:0] Y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] R
);

  fp_t               x_w, y_w, exc_r, rnd_r, r_q;
  logic [1:0]        state;
  logic              sign;
  logic signed [6:0] e, e_init, e_rnd;
  logic [3:0]        excsel;
  logic              special, accept, x_lt_y;
  logic [WF:0]       sig_x, sig_y;
  logic [12:0]       rem_init;
  logic              div_done, sticky, round_up, carry;
  logic [WF+1:0]     quot;
  logic [WF:0]       mant_sum;

  assign x_w       = X;
  assign y_w       = Y;
  assign excsel    = {x_w.exc, y_w.exc};
  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign R         = r_q;

  always_comb begin
    special = 1'b1;
    exc_r   = fp_special(EXC_NORMAL, x_w.sign ^ y_w.sign);
    if (x_w.exc == EXC_NAN || y_w.exc == EXC_NAN) begin
      exc_r.exc = EXC_NAN;
    end else begin
      case (excsel)
        {EXC_ZERO, EXC_ZERO}, {EXC_INF, EXC_INF}:                           exc_r.exc = EXC_NAN;
        {EXC_ZERO, EXC_NORMAL}, {EXC_ZERO, EXC_INF}, {EXC_NORMAL, EXC_INF}: exc_r.exc = EXC_ZERO;
        {EXC_NORMAL, EXC_ZERO}, {EXC_INF, EXC_ZERO}, {EXC_INF, EXC_NORMAL}: exc_r.exc = EXC_INF;
        default:                                                            special = 1'b0;
      endcase
    end
  end

  assign sig_x    = {1'b1, x_w.frac};
  assign sig_y    = {1'b1, y_w.frac};
  assign x_lt_y   = (sig_x < sig_y);
  assign rem_init = x_lt_y ? {1'b0, sig_x, 1'b0} : {2'b00, sig_x};
  assign e_init   = {3'b000, x_w.exp} - {3'b000, y_w.exp} + 7'(BIAS) - {6'd0, x_lt_y};

  sigdiv_radix2 u_sigdiv (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && !special),
    .rem_init (rem_init),
    .divisor  (sig_y),
    .done     (div_done),
    .quot     (quot),
    .sticky   (sticky)
  );

  // quot[0] is the guard bit; the leading one dropping out of the 11-bit sum marks a carry-out
  assign round_up = quot[0] & (sticky | quot[1]);
  assign mant_sum = quot[WF+1:1] + {{WF{1'b0}}, round_up};
  assign carry    = ~mant_sum[WF];
  assign e_rnd    = e + $signed({6'd0, carry});

  always_comb begin
    rnd_r = fp_special(EXC_NORMAL, sign);
    if (e_rnd > 7'sd15) begin
      rnd_r.exc = EXC_INF;
    end else if (e_rnd < 7'sd0) begin
      rnd_r.exc = EXC_ZERO;
    end else begin
      rnd_r.exp  = e_rnd[WE-1:0];
      rnd_r.frac = mant_sum[WF-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      r_q   <= '0;
      sign  <= 1'b0;
      e     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sign <= x_w.sign ^ y_w.sign;
            if (special) begin
              r_q   <= exc_r;
              state <= ST_DONE;
            end else begin
              e     <= e_init;
              state <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          if (div_done) state <= ST_ROUND;
        end
        ST_ROUND: begin
          r_q   <= rnd_r;
          state <= ST_DONE;
        end
        default: begin
          if (out_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_iter.sv
// Self-checking bench for fdiv_iter: directed vectors with literal results,
// plus a real-arithmetic reference model checked on every valid output cycle.
module tb_fdiv_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [16:0] X, Y;
  logic        out_valid, out_ready;
  logic [16:0] R;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  typedef struct {
    logic [16:0] r;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  logic front_seen = 1'b0;

  fdiv_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: exact quotient of the significands scaled to 13 bits, then RNE.
  function automatic logic [16:0] model(input logic [16:0] x, input logic [16:0] y);
    logic [1:0] xe, ye;
    logic       s;
    int         e, mant;
    longint     sx, sy, num, q, r;
    logic       guard, stk;
    logic [31:0] ev, mv;
    xe = x[16:15];
    ye = y[16:15];
    s  = x[14] ^ y[14];
    if (xe == 2'b11 || ye == 2'b11) return {2'b11, s, 14'd0};
    if ((xe == 2'b00 && ye == 2'b00) || (xe == 2'b10 && ye == 2'b10)) return {2'b11, s, 14'd0};
    if (xe == 2'b00 || ye == 2'b10) return {2'b00, s, 14'd0};
    if (ye == 2'b00 || xe == 2'b10) return {2'b10, s, 14'd0};
    sx = 1024 + longint'(x[9:0]);
    sy = 1024 + longint'(y[9:0]);
    e  = int'(x[13:10]) - int'(y[13:10]) + 7;
    if (sx < sy) begin
      num = sx * 8192;
      e   = e - 1;
    end else begin
      num = sx * 4096;
    end
    q     = num / sy;
    r     = num % sy;
    mant  = int'(q / 4);
    guard = ((q / 2) % 2) != 0;
    stk   = ((q % 2) != 0) || (r != 0);
    if (guard && (stk || (mant % 2) != 0)) mant = mant + 1;
    if (mant == 2048) begin
      mant = 1024;
      e    = e + 1;
    end
    if (e > 15) return {2'b10, s, 14'd0};
    if (e < 0)  return {2'b00, s, 14'd0};
    ev = e;
    mv = mant;
    return {2'b01, s, ev[3:0], mv[9:0]};
  endfunction

  // Compare process: every valid-output cycle against the model queue.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      front_seen = 1'b0;
    end else begin
      if (out_valid) begin
        chk("in_ready_in_done", in_ready, 0);
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          chk("r_vs_model", R, exp_q[0].r);
          if (!front_seen) begin
            chk("latency_vs_model", cyc - exp_q[0].acc, exp_q[0].lat);
            front_seen = 1'b1;
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            front_seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        chk("no_overlap", exp_q.size(), 0);
        exp_q.push_back('{model(X, Y), (X[16:15] == 2'b01 && Y[16:15] == 2'b01) ? 14 : 1, cyc});
      end
    end
  end

  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [16:0] x, input logic [16:0] y, input logic [16:0] exp_r,
                        input int exp_lat, input int stall);
    int n;
    @(posedge clk); #1;
    X = x; Y = y; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    X = 17'($urandom);
    Y = 17'($urandom);
    wait_out(n);
    chk("latency", n, exp_lat);
    chk("result", R, exp_r);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_hold_r", R, exp_r);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_hs", out_valid, 0);
  endtask

  initial begin
    int n;
    logic [16:0] rx, ry;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = '0; Y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_r", R, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    run_op(17'h09C00, 17'h0A000, 17'h09800, 14, 0);
    run_op(17'h0A200, 17'h0A000, 17'h09E00, 14, 0);
    run_op(17'h09C00, 17'h0A200, 17'h09555, 14, 0);
    run_op(17'h0DC00, 17'h0A000, 17'h0D800, 14, 0);
    run_op(17'h0BFFF, 17'h08000, 17'h10000, 14, 0);
    run_op(17'h08000, 17'h0BFFF, 17'h00000, 14, 0);
    run_op(17'h00000, 17'h00000, 17'h18000, 1, 0);
    run_op(17'h09C00, 17'h00000, 17'h10000, 1, 0);
    run_op(17'h00000, 17'h09C00, 17'h00000, 1, 0);
    run_op(17'h10000, 17'h10000, 17'h18000, 1, 0);
    run_op(17'h18000, 17'h09C00, 17'h18000, 1, 0);
    run_op(17'h0A200, 17'h0A000, 17'h09E00, 14, 5);

    // Next operands held valid while the previous result is back-pressured
    @(posedge clk); #1;
    X = 17'h0A200; Y = 17'h0A000; in_valid = 1'b1;
    @(posedge clk); #1;
    X = 17'h09C00; Y = 17'h0A200;
    wait_out(n);
    chk("tp_first_latency", n, 14);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("tp_in_ready_low", in_ready, 0);
      chk("tp_hold_r", R, 17'h09E00);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("tp_ready_after_hs", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(n);
    chk("tp_second_latency", n, 14);
    chk("tp_second_r", R, 17'h09555);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a division
    @(posedge clk); #1;
    X = 17'h09C00; Y = 17'h0A000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_r", R, 0);
    chk("midrst_in_ready_2", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_out", out_valid, 0);
    end
    run_op(17'h09C00, 17'h0A000, 17'h09800, 14, 0);

    // Mixed vectors checked against the reference model
    for (int i = 0; i < 30; i++) begin
      rx = {2'b01, 15'($urandom)};
      ry = {2'b01, 15'($urandom)};
      if ($urandom_range(0, 4) == 0) rx[16:15] = 2'($urandom);
      if ($urandom_range(0, 4) == 0) ry[16:15] = 2'($urandom);
      run_op(rx, ry, model(rx, ry), (rx[16:15] == 2'b01 && ry[16:15] == 2'b01) ? 14 : 1,
             $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fdiv_iter.md
Name: fdiv_iter

Overview:
- Iterative floating-point divider R = X / Y.
- Uses the same 17-bit FloPoCo-style operand format as the team's fmul core: wE=4, wF=10, bias 7, 2-bit exception field.
- Inverse-operation companion to fmul in the HLS operator library. Intended for low-area use where divide throughput is not critical.
- Restoring radix-2 significand division, one quotient bit per cycle, with valid/ready handshakes on both sides.

Parameters:
- WE, 4, exponent field width (fixed for this instance; widths below assume it)
- WF, 10, fraction field width
- BIAS, 7, exponent bias (2^(WE-1)-1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands X,Y valid
- in_ready  out  1  divider can accept operands
- X  in  17  dividend: [16:15] exc, [14] sign, [13:10] exp, [9:0] frac
- Y  in  17  divisor, same format
- out_valid  out  1  R valid
- out_ready  in  1  consumer accepts R
- R  out  17  quotient, same format

Behaviour:
- Exception encoding: 00 zero, 01 normal, 10 infinity, 11 NaN.
- Reset:
  - State goes to IDLE; out_valid=0; R=0.
  - in_ready=0 while rst=1.
  - Reset mid-division abandons the operation with no output.
- States: IDLE, DIV, ROUND, DONE.
- in_ready is 1 only in IDLE. It is a combinational decode of state.
- IDLE, on in_valid & in_ready:
  - Capture sign = X[14]^Y[14].
  - Decode excsel = {X.exc, Y.exc}.
  - Go to DONE with R registered directly if excsel is exceptional; otherwise go to DIV with count=0.
- Exception result (sign is always X.sign^Y.sign):
  - Either operand NaN -> NaN.
  - 00/00 -> NaN; 10/10 -> NaN.
  - 00/01, 00/10, 01/10 -> zero.
  - 01/00, 10/00, 10/01 -> infinity.
  - 01/01 -> compute.
  - Exponent and fraction of an exceptional R are 0.
- Setup on accept (01/01):
  - sigX = {1,X.frac}, sigY = {1,Y.frac}.
  - e = X.exp - Y.exp + BIAS, held as a 7-bit signed value.
  - If sigX < sigY: rem = 2*sigX and e = e-1. Otherwise rem = sigX.
  - rem is 13 bits wide.
- DIV: 12 cycles, one quotient bit per cycle.
  - q_bit = (rem >= sigY).
  - rem = (rem - q_bit*sigY) << 1.
  - Shift q_bit into a 12-bit quotient.
  - Bit 11 is always 1; bits 10:1 are the fraction; bit 0 is guard.
  - After count==11, go to ROUND.
- ROUND: round to nearest even.
  - sticky = (rem != 0).
  - Round up if guard & (sticky | q[1]).
  - A fraction carry-out sets frac=0 and e=e+1.
  - e > 15 -> infinity; e < 0 -> zero (no subnormals); else normal with exp=e[3:0].
  - Register R, then go to DONE.
- DONE:
  - out_valid=1 and R is held stable until out_valid & out_ready, then go to IDLE.
  - in_ready=0 in DONE, so no overlap of operations. The next accept occurs no earlier than the cycle after the output handshake.
- Latency, counted from the accepting edge to the first cycle with out_valid=1:
  - Normal operands: 14 edges (12 DIV + 1 ROUND + 1 setup into DIV).
  - Exceptional operands: 1 edge.
- in_valid and operands are ignored outside IDLE. X and Y are not required to stay stable after the accept.

Decomposition:
- Shared package fp_pkg holds:
  - WE, WF, BIAS constants.
  - EXC_ZERO/EXC_NORMAL/EXC_INF/EXC_NAN localparams.
  - A struct typedef for the 17-bit {exc, sign, exp, frac} word.
  - The state enum for fdiv_iter.
- One sub-module, sigdiv_radix2: the remainder/quotient register, compare-subtract-shift step, and counter. It provides start/done signals plus quotient and sticky outputs. Exception decode and rounding stay in fdiv_iter.

Test Plan:
- 1.0/2.0 and 3.0/2.0:
  - X=0x09C00, Y=0x0A000 -> R=0x09800 (0.5), out_valid 14 edges after accept.
  - X=0x0A200, Y=0x0A000 -> R=0x09E00 (1.5).
- Normalisation path and round-down: X=0x09C00, Y=0x0A200 (1/3) -> R=0x09555, guard=0, sticky=1, so no round-up.
- Sign and overflow/underflow:
  - X=0x0DC00 (-1.0), Y=0x0A000 -> R=0x0D800 (-0.5).
  - X=0x0BFFF, Y=0x08000 -> R=0x10000 (+inf).
  - X=0x08000, Y=0x0BFFF -> R=0x00000 (zero).
- Exceptions, each out_valid 1 edge after accept:
  - 0/0 (0x00000/0x00000) -> 0x18000.
  - 1/0 -> 0x10000.
  - 0/1 -> 0x00000.
  - inf/inf -> 0x18000.
  - NaN/1 -> NaN.
- Backpressure and throughput:
  - Hold out_ready=0 for 5 cycles in DONE -> R stable, in_ready=0.
  - New in_valid held high is accepted only after the out handshake.
  - Two back-to-back operations return results in order.
- Reset mid-operation: assert rst at DIV count 5 -> next cycle out_valid=0, R=0, in_ready=0 during rst. After release, in_ready=1 and a fresh 1.0/2.0 returns 0x09800.
